// File: rtl/lot_pkg.sv
// Shared constants and types for the parking-lot sensor conditioning path.
package lot_pkg;

  // Beam sensors are active-low: 0 means something is blocking the beam.
  localparam logic SENSOR_CLEAR   = 1'b1;
  localparam logic SENSOR_BLOCKED = 1'b0;

  localparam int DEBOUNCE_CYCLES_DEF = 3;
  localparam int STUCK_CYCLES_DEF    = 1000;
  localparam int GLITCH_CNT_W        = 8;
  localparam int NUM_CH              = 2;

  // Per-channel result bundle handed from the debouncer to the top level.
  typedef struct packed {
    logic level;
    logic stuck;
    logic glitch;
  } chan_out_t;

  // Saturating add of a small increment onto the glitch accumulator.
  function automatic logic [GLITCH_CNT_W-1:0] sat_add(
    input logic [GLITCH_CNT_W-1:0] acc,
    input logic [1:0]              inc
  );
    logic [GLITCH_CNT_W:0] sum;
    sum = {1'b0, acc} + {{(GLITCH_CNT_W-1){1'b0}}, inc};
    if (sum[GLITCH_CNT_W]) return '1;
    return sum[GLITCH_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/lot_sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, stable-count debounce, stuck-low
// detector and a one-cycle pulse for every rejected transition.
module lot_sensor_debounce
  import lot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw_i,
  output chan_out_t out_o
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCNT_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STUCK_CYCLES);

  logic              s1_q, s2_q;
  logic              lvl_q, lvl_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              stuck_q, stuck_d;
  logic              glitch;

  // A pending transition that collapses back to the output level is a glitch.
  assign glitch = (s2_q == lvl_q) && (dcnt_q != '0);

  // Next-state for debounce and stuck counters, all from registered values.
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    if (s2_q == lvl_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      lvl_d  = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end

    scnt_d = scnt_q;
    if (lvl_q == SENSOR_BLOCKED) begin
      if (scnt_q != SCNT_MAX) scnt_d = scnt_q + SCNT_W'(1);
    end else begin
      scnt_d = '0;
    end

    // Gated by the live level so the flag drops one edge after release.
    stuck_d = (scnt_q == SCNT_MAX) && (lvl_q == SENSOR_BLOCKED);
  end

  // Synchronizer and channel state; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= SENSOR_CLEAR;
      s2_q    <= SENSOR_CLEAR;
      lvl_q   <= SENSOR_CLEAR;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      stuck_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      stuck_q <= stuck_d;
    end
  end

  assign out_o.level  = lvl_q;
  assign out_o.stuck  = stuck_q;
  assign out_o.glitch = glitch;

endmodule

// File: rtl/lot_sensor_conditioner.sv
// Conditions the outer (SD1) and inner (SD2) beam sensors for the occupancy
// tracker and accumulates rejected-glitch diagnostics across both channels.
module lot_sensor_conditioner
  import lot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SD1_raw,
  input  logic                    SD2_raw,
  output logic                    SD1,
  output logic                    SD2,
  output logic [1:0]              stuck,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  logic [NUM_CH-1:0]    raw;
  chan_out_t            ch   [NUM_CH];
  logic [NUM_CH-1:0]    glitch;
  logic [1:0]           glitch_sum;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  assign raw = {SD2_raw, SD1_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lot_sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[i]),
      .out_o (ch[i])
    );
    assign stuck[i]  = ch[i].stuck;
    assign glitch[i] = ch[i].glitch;
  end

  assign SD1        = ch[0].level;
  assign SD2        = ch[1].level;
  assign glitch_sum = {1'b0, glitch[0]} + {1'b0, glitch[1]};

  // Saturating glitch accumulator; both channels may add on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) glitch_cnt_q <= '0;
    else      glitch_cnt_q <= sat_add(glitch_cnt_q, glitch_sum);
  end

  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: doc/lot_sensor_conditioner.md
# lot_sensor_conditioner

Input conditioning stage for the two parking-lot entry/exit beam sensors, sitting directly upstream of the lot occupancy tracker. Each raw sensor is asynchronous and bouncy. The block synchronizes it, debounces it with a stable-count filter, and drives clean active-low SD1/SD2 levels that the tracker consumes unchanged. It also reports a blocked-too-long sensor (stuck) and counts rejected glitches for diagnostics.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 3: consecutive stable cycles required before an output level changes; legal range 1..255.
- STUCK_CYCLES, default 1000: consecutive cycles with a debounced output low before the stuck flag for that channel asserts; must be at least 1.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; 0 on a rising edge resets the block.
- SD1_raw  in  1  outer sensor, asynchronous, active-low (0 = beam blocked).
- SD2_raw  in  1  inner sensor, asynchronous, active-low.
- SD1  out  1  debounced outer sensor, active-low; feeds the tracker.
- SD2  out  1  debounced inner sensor, active-low; feeds the tracker.
- stuck  out  2  bit 0 = SD1 stuck low, bit 1 = SD2 stuck low.
- glitch_cnt  out  8  saturating count of rejected transitions, both channels combined.

## Operation
- Each channel is synchronized by a 2-flop chain (s1, s2), both reset to 1.
- Debounce per channel uses a counter dcnt of width $clog2(DEBOUNCE_CYCLES+1), reset 0. Each edge:
  - s2 == out: dcnt is cleared. If dcnt was nonzero, the channel raises a one-cycle glitch pulse.
  - s2 != out and dcnt == DEBOUNCE_CYCLES-1: out is set to s2 and dcnt is cleared. No glitch pulse.
  - otherwise: dcnt is incremented.
- Stuck detection per channel uses a counter scnt of width $clog2(STUCK_CYCLES+1), reset 0.
  - While out == 0, scnt increments and saturates at STUCK_CYCLES.
  - When out == 1, scnt is cleared.
  - stuck[i] = (scnt == STUCK_CYCLES), registered. It deasserts on the edge after out returns to 1.
- glitch_cnt adds the number of glitch pulses this cycle (0, 1 or 2) and saturates at 255. Simultaneous glitches on both channels add 2, saturating at 255 (254 + 2 gives 255).
- Channels are fully independent. Simultaneous transitions on both channels are debounced in parallel with identical latency.
- No ordering or direction checks are done here; sequence errors belong to the tracker.

## Timing
- Reset values:
  - SD1 = SD2 = 1 (sensors clear).
  - stuck = 2'b00.
  - glitch_cnt = 0.
  - all sync flops = 1; all counters = 0.
- Latency from a clean raw change to the output is DEBOUNCE_CYCLES+2 rising edges, counted from the first edge after the change. For DEBOUNCE_CYCLES=3 the output changes on the 5th edge.
- Pulse rejection:
  - A raw pulse whose s2 image lasts fewer than DEBOUNCE_CYCLES cycles never reaches the output.
  - It increments glitch_cnt by 1 on the edge at which s2 returns to the output level.
- Stuck timing: stuck[i] rises STUCK_CYCLES+1 edges after out[i] falls.
- Reset mid-debounce: on the reset edge, all counters clear and the outputs return to 1. A raw level still low after reset is re-debounced with the full latency.
- The outputs are registered, with no combinational path from input to output.

## Structure
- Shared package lot_pkg holds:
  - SENSOR_CLEAR = 1'b1 and SENSOR_BLOCKED = 1'b0.
  - default DEBOUNCE_CYCLES and STUCK_CYCLES.
  - GLITCH_CNT_W = 8.
- One sub-module, lot_sensor_debounce, instantiated once per channel. It contains the sync chain, dcnt, scnt, the stuck flag and the glitch pulse output.
- The top level holds only the two instances and the glitch_cnt accumulator.

## Test plan
Bench uses DEBOUNCE_CYCLES=3 and STUCK_CYCLES=20.
- Clean entry: SD1_raw goes to 0 for 4 cycles, then SD2_raw goes to 0, releasing in the same order -> SD1 falls 5 edges after its raw edge, SD2 follows 4 edges later, glitch_cnt stays 0.
- Glitch: SD1_raw goes to 0 for 2 cycles, then returns to 1 -> SD1 stays 1 and glitch_cnt = 1. Then both raws pulse 1 cycle on the same cycle -> glitch_cnt = 3.
- Stuck: SD2_raw held at 0 for 40 cycles -> SD2 falls at edge 5, stuck = 2'b10 at edge 26; release -> SD2 rises 5 edges later and stuck = 00 one edge after that.
- Reset mid-debounce: SD1_raw falls, and rst = 0 for 1 edge at edge 3 -> SD1 stays 1 during reset; SD1 falls 5 edges after rst returns to 1 with SD1_raw still 0.
- Saturation: 300 one-cycle pulses on SD1_raw -> glitch_cnt reaches 255 and holds; SD1 never leaves 1.
- Tracker loop: instance feeding lotTracker, 17 entries then 17 exits with bounce injected on every raw edge -> tracker count and err are identical to the unbounced run.
